ysyx_22041211_ifu: RTL

- Instruction fetch unit; sits directly upstream of the decoder and supplies its instruction word and PC.
- Owns the architectural PC and issues one read at a time over a valid/ready address channel and a valid/ready response channel.
- Presents each fetched instruction to the decoder over a valid/ready handshake.
- Accepts PC redirects (taken branch, jal/jalr) from execute and discards any stale fetch in flight.

---
 rtl/ysyx_22041211_ifu_if.sv | 27 ++
 rtl/ysyx_22041211_ifu.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/ysyx_22041211_ifu_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ysyx_22041211_ifu_if : fetch address/response channel between IFU and mem  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface ysyx_22041211_ifu_if #(
  parameter int ADDR_W = 32
) ();
  logic [ADDR_W-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rresp, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rresp, rvalid
  );
endinterface
`default_nettype wire

// File: rtl/ysyx_22041211_ifu.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ysyx_22041211_ifu : single-outstanding instruction fetch unit with redirect |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ysyx_22041211_ifu #(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ysyx_22041211_ifu_if.master   mem,
  output logic [31:0]           inst_o,
  output logic [ADDR_W-1:0]     pc_o,
  output logic                  fetch_err_o,
  output logic                  inst_valid_o,
  input  logic                  inst_ready_i,
  input  logic                  redirect_valid_i,
  input  logic [ADDR_W-1:0]     redirect_pc_i,
  output logic [31:0]           fetch_cnt_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_OUT  = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] req_addr_q, req_addr_d;
  logic              drop_q, drop_d;
  logic [31:0]       fetch_cnt_q, fetch_cnt_d;
  logic [31:0]       inst_q, inst_d;
  logic [ADDR_W-1:0] pc_out_q, pc_out_d;
  logic              err_q, err_d;

  logic [ADDR_W-1:0] w_target;
  logic [ADDR_W-1:0] w_next_pc;

  assign w_target = {redirect_pc_i[ADDR_W-1:2], 2'b00};

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_addr_d  = req_addr_q;
    drop_d      = drop_q;
    fetch_cnt_d = fetch_cnt_q;
    inst_d      = inst_q;
    pc_out_d    = pc_out_q;
    err_d       = err_q;
    w_next_pc   = '0;

    case (state_q)
      S_IDLE: begin
        req_addr_d = pc_q;
        state_d    = S_REQ;
      end
      S_REQ: begin
        // The address already on the bus stays put; only the architectural PC moves.
        if (redirect_valid_i) begin
          pc_d   = w_target;
          drop_d = 1'b1;
        end
        if (mem.arready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem.rvalid) begin
          if (!drop_q && !redirect_valid_i) begin
            inst_d   = mem.rdata;
            pc_out_d = req_addr_q;
            err_d    = (mem.rresp != 2'b00);
            state_d  = S_OUT;
          end else begin
            w_next_pc  = redirect_valid_i ? w_target : pc_q;
            drop_d     = 1'b0;
            req_addr_d = w_next_pc;
            pc_d       = w_next_pc;
            state_d    = S_REQ;
          end
        end else if (redirect_valid_i) begin
          pc_d   = w_target;
          drop_d = 1'b1;
        end
      end
      S_OUT: begin
        if (inst_ready_i) begin
          // A redirect coinciding with the handshake still counts the transfer.
          fetch_cnt_d = fetch_cnt_q + 32'd1;
          w_next_pc   = redirect_valid_i ? w_target : (pc_out_q + ADDR_W'(4));
          pc_d        = w_next_pc;
          req_addr_d  = w_next_pc;
          state_d     = S_REQ;
        end else if (redirect_valid_i) begin
          pc_d       = w_target;
          req_addr_d = w_target;
          state_d    = S_REQ;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      req_addr_q  <= RESET_PC;
      drop_q      <= 1'b0;
      fetch_cnt_q <= 32'd0;
      inst_q      <= 32'd0;
      pc_out_q    <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_addr_q  <= req_addr_d;
      drop_q      <= drop_d;
      fetch_cnt_q <= fetch_cnt_d;
      inst_q      <= inst_d;
      pc_out_q    <= pc_out_d;
      err_q       <= err_d;
    end
  end

  assign mem.araddr   = req_addr_q;
  assign mem.arvalid  = (state_q == S_REQ);
  assign mem.rready   = (state_q == S_WAIT);
  assign inst_valid_o = (state_q == S_OUT);
  assign inst_o       = inst_q;
  assign pc_o         = pc_out_q;
  assign fetch_err_o  = err_q;
  assign fetch_cnt_o  = fetch_cnt_q;

endmodule
`default_nettype wire
